// File: rtl/ip_checksum_insert.sv
// Transmit-side IPv4 header checksum generator for the 64-bit datapath.
// Buffers the first five data words, recomputes the header checksum, rewrites it, then streams the packet.

module ip_checksum_insert #(
    parameter int DATA_WIDTH = 64,
    parameter int CTRL_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [CTRL_WIDTH-1:0] in_ctrl,
    input  logic                  in_wr,
    output logic                  in_rdy,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [CTRL_WIDTH-1:0] out_ctrl,
    output logic                  out_wr,
    input  logic                  out_rdy,
    output logic                  csum_inserted,
    output logic                  csum_bypassed
);

    localparam int WORD_W = DATA_WIDTH + CTRL_WIDTH;

    localparam logic [2:0] S_MODULE_HDRS = 3'd0;
    localparam logic [2:0] S_COLLECT     = 3'd1;
    localparam logic [2:0] S_FOLD1       = 3'd2;
    localparam logic [2:0] S_FOLD2       = 3'd3;
    localparam logic [2:0] S_DRAIN       = 3'd4;
    localparam logic [2:0] S_PAYLOAD     = 3'd5;

    // One end-around-carry step of the one's-complement sum.
    function automatic logic [19:0] fold_carry(input logic [19:0] s);
        return {4'd0, s[15:0]} + {16'd0, s[19:16]};
    endfunction

    function automatic logic [19:0] zext16(input logic [15:0] v);
        return {4'd0, v};
    endfunction

    logic [2:0]            state_q, state_d;
    logic [2:0]            cnt_q, cnt_d;
    logic [2:0]            rd_idx_q, rd_idx_d;
    logic [2:0]            last_idx_q, last_idx_d;
    logic                  eop_buf_q, eop_buf_d;
    logic                  ip_ok_q, ip_ok_d;
    logic [19:0]           sum_q, sum_d;
    logic [WORD_W-1:0]     buf_q [0:4];
    logic [WORD_W-1:0]     buf_d [0:4];
    logic                  out_wr_q, out_wr_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic [CTRL_WIDTH-1:0] out_ctrl_q, out_ctrl_d;
    logic                  csum_inserted_q, csum_inserted_d;
    logic                  csum_bypassed_q, csum_bypassed_d;
    logic                  run_q;

    logic                  out_free_s;
    logic                  in_rdy_s;
    logic                  in_xfer_s;
    logic                  in_ctrl_nz_s;
    logic [WORD_W-1:0]     in_word_s;
    logic [19:0]           sum_fold_s;

    assign out_free_s   = ~out_wr_q | out_rdy;
    assign in_xfer_s    = in_wr & in_rdy_s;
    assign in_ctrl_nz_s = |in_ctrl;
    assign in_word_s    = {in_ctrl, in_data};
    assign sum_fold_s   = fold_carry(sum_q);

    // Input ready: pass-through states follow the output register, collect always accepts.
    always_comb begin
        case (state_q)
            S_MODULE_HDRS, S_PAYLOAD: in_rdy_s = run_q & out_free_s;
            S_COLLECT:                in_rdy_s = run_q;
            default:                  in_rdy_s = 1'b0;
        endcase
    end

    // Next-state, accumulator, buffer and output-register logic.
    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        rd_idx_d        = rd_idx_q;
        last_idx_d      = last_idx_q;
        eop_buf_d       = eop_buf_q;
        ip_ok_d         = ip_ok_q;
        sum_d           = sum_q;
        buf_d           = buf_q;
        out_wr_d        = out_wr_q & ~out_rdy;
        out_data_d      = out_data_q;
        out_ctrl_d      = out_ctrl_q;
        csum_inserted_d = 1'b0;
        csum_bypassed_d = 1'b0;
        case (state_q)
            S_MODULE_HDRS: begin
                if (in_xfer_s && in_ctrl_nz_s) begin
                    out_wr_d   = 1'b1;
                    out_data_d = in_data;
                    out_ctrl_d = in_ctrl;
                end else if (in_xfer_s) begin
                    buf_d[0]  = in_word_s;
                    cnt_d     = 3'd1;
                    sum_d     = 20'd0;
                    ip_ok_d   = 1'b0;
                    eop_buf_d = 1'b0;
                    state_d   = S_COLLECT;
                end else begin
                    state_d = S_MODULE_HDRS;
                end
            end
            S_COLLECT: begin
                if (in_xfer_s) begin
                    buf_d[cnt_q] = in_word_s;
                    // The checksum field (w3[63:48]) is never added.
                    case (cnt_q)
                        3'd1: begin
                            sum_d   = sum_q + zext16(in_data[15:0]);
                            ip_ok_d = (in_data[31:16] == 16'h0800) && (in_data[15:8] == 8'h45);
                        end
                        3'd2: sum_d = sum_q + zext16(in_data[63:48]) + zext16(in_data[47:32])
                                            + zext16(in_data[31:16]) + zext16(in_data[15:0]);
                        3'd3: sum_d = sum_q + zext16(in_data[47:32]) + zext16(in_data[31:16])
                                            + zext16(in_data[15:0]);
                        3'd4: sum_d = sum_q + zext16(in_data[63:48]);
                        default: sum_d = sum_q;
                    endcase
                    if (cnt_q == 3'd4) begin
                        last_idx_d = 3'd4;
                        eop_buf_d  = in_ctrl_nz_s;
                        state_d    = S_FOLD1;
                    end else if (in_ctrl_nz_s) begin
                        last_idx_d      = cnt_q;
                        eop_buf_d       = 1'b1;
                        rd_idx_d        = 3'd0;
                        csum_bypassed_d = 1'b1;
                        state_d         = S_DRAIN;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end else begin
                    state_d = S_COLLECT;
                end
            end
            S_FOLD1: begin
                sum_d   = sum_fold_s;
                state_d = S_FOLD2;
            end
            S_FOLD2: begin
                sum_d    = sum_fold_s;
                rd_idx_d = 3'd0;
                state_d  = S_DRAIN;
                if (ip_ok_q) begin
                    buf_d[3][63:48] = ~sum_fold_s[15:0];
                    csum_inserted_d = 1'b1;
                end else begin
                    csum_bypassed_d = 1'b1;
                end
            end
            S_DRAIN: begin
                if (out_free_s) begin
                    out_wr_d   = 1'b1;
                    out_data_d = buf_q[rd_idx_q][DATA_WIDTH-1:0];
                    out_ctrl_d = buf_q[rd_idx_q][WORD_W-1:DATA_WIDTH];
                    if (rd_idx_q == last_idx_q) begin
                        state_d = eop_buf_q ? S_MODULE_HDRS : S_PAYLOAD;
                    end else begin
                        rd_idx_d = rd_idx_q + 3'd1;
                    end
                end else begin
                    state_d = S_DRAIN;
                end
            end
            S_PAYLOAD: begin
                if (in_xfer_s) begin
                    out_wr_d   = 1'b1;
                    out_data_d = in_data;
                    out_ctrl_d = in_ctrl;
                    if (in_ctrl_nz_s) begin
                        state_d = S_MODULE_HDRS;
                    end else begin
                        state_d = S_PAYLOAD;
                    end
                end else begin
                    state_d = S_PAYLOAD;
                end
            end
            default: begin
                state_d = S_MODULE_HDRS;
            end
        endcase
    end

    // State and datapath registers; reset discards any buffered header.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= S_MODULE_HDRS;
            cnt_q           <= 3'd0;
            rd_idx_q        <= 3'd0;
            last_idx_q      <= 3'd0;
            eop_buf_q       <= 1'b0;
            ip_ok_q         <= 1'b0;
            sum_q           <= 20'd0;
            out_wr_q        <= 1'b0;
            out_data_q      <= '0;
            out_ctrl_q      <= '0;
            csum_inserted_q <= 1'b0;
            csum_bypassed_q <= 1'b0;
            run_q           <= 1'b0;
            for (int i = 0; i < 5; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            rd_idx_q        <= rd_idx_d;
            last_idx_q      <= last_idx_d;
            eop_buf_q       <= eop_buf_d;
            ip_ok_q         <= ip_ok_d;
            sum_q           <= sum_d;
            out_wr_q        <= out_wr_d;
            out_data_q      <= out_data_d;
            out_ctrl_q      <= out_ctrl_d;
            csum_inserted_q <= csum_inserted_d;
            csum_bypassed_q <= csum_bypassed_d;
            run_q           <= 1'b1;
            buf_q           <= buf_d;
        end
    end

    assign in_rdy        = in_rdy_s;
    assign out_wr        = out_wr_q;
    assign out_data      = out_data_q;
    assign out_ctrl      = out_ctrl_q;
    assign csum_inserted = csum_inserted_q;
    assign csum_bypassed = csum_bypassed_q;

endmodule

// File: tb/tb_ip_checksum_insert.sv
// Randomized bench for ip_checksum_insert against a packet-level checksum model.

module tb_ip_checksum_insert;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [63:0] in_data;
    logic [7:0]  in_ctrl;
    logic        in_wr;
    logic        in_rdy;
    logic [63:0] out_data;
    logic [7:0]  out_ctrl;
    logic        out_wr;
    logic        out_rdy;
    logic        csum_inserted;
    logic        csum_bypassed;

    int n_vec  = 0;
    int n_miss = 0;

    logic [71:0] pkt_q[$];
    logic [71:0] exp_q[$];
    logic [71:0] got_q[$];
    int ins_cnt, byp_cnt, e_ins, e_byp;
    bit rand_rdy, hold_rdy, stuck;
    bit prev_stall;
    logic [72:0] prev_out;

    always #5 clk = ~clk;

    ip_checksum_insert #(.DATA_WIDTH(64), .CTRL_WIDTH(8)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_data(in_data), .in_ctrl(in_ctrl), .in_wr(in_wr), .in_rdy(in_rdy),
        .out_data(out_data), .out_ctrl(out_ctrl), .out_wr(out_wr), .out_rdy(out_rdy),
        .csum_inserted(csum_inserted), .csum_bypassed(csum_bypassed)
    );

    // Downstream ready: always, random 50%, or held low.
    initial begin
        out_rdy = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (hold_rdy) out_rdy = 1'b0;
            else if (rand_rdy) out_rdy = 1'($urandom_range(0, 1));
            else out_rdy = 1'b1;
        end
    end

    // Output capture and pulse counting, sampled mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (reset_n) begin
                if (out_wr && out_rdy) got_q.push_back({out_ctrl, out_data});
                if (csum_inserted) ins_cnt++;
                if (csum_bypassed) byp_cnt++;
            end
        end
    end

    // A stalled output word must stay put until it is taken.
    initial begin
        prev_stall = 1'b0;
        forever begin
            @(negedge clk);
            if (reset_n && prev_stall) begin
                n_vec++;
                if ({out_wr, out_ctrl, out_data} !== prev_out) begin
                    n_miss++;
                    $display("FAIL stall_hold: got %h, required %h", {out_wr, out_ctrl, out_data}, prev_out);
                end
            end
            prev_stall = reset_n && out_wr && !out_rdy;
            prev_out   = {out_wr, out_ctrl, out_data};
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: still running at %0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic start_test();
        got_q.delete();
        exp_q.delete();
        ins_cnt = 0;
        byp_cnt = 0;
        e_ins   = 0;
        e_byp   = 0;
    endtask

    task automatic make_pkt(input int n_mh, input int n_data, input logic [15:0] etype, input logic [7:0] vi);
        logic [63:0] d;
        logic [7:0]  c;
        pkt_q.delete();
        for (int i = 0; i < n_mh; i++) pkt_q.push_back({8'hFF, $urandom, $urandom});
        for (int i = 0; i < n_data; i++) begin
            d = {$urandom, $urandom};
            c = (i == n_data - 1) ? (8'd1 << $urandom_range(0, 7)) : 8'd0;
            if (i == 1) begin
                d[31:16] = etype;
                d[15:8]  = vi;
            end
            pkt_q.push_back({c, d});
        end
    endtask

    // Reference: sum the ten header halfwords (checksum taken as zero), fold until no carry, invert.
    function automatic void build_expected();
        int first, n;
        int unsigned s;
        logic [71:0] w1, w2, w3, w4;
        bit ok;
        first = 0;
        while (first < pkt_q.size() && pkt_q[first][71:64] != 8'd0) first++;
        n = 0;
        for (int i = first; i < pkt_q.size(); i++) begin
            n++;
            if (pkt_q[i][71:64] != 8'd0) break;
        end
        ok = 1'b0;
        w3 = 72'd0;
        if (n >= 5) begin
            w1 = pkt_q[first + 1];
            w2 = pkt_q[first + 2];
            w3 = pkt_q[first + 3];
            w4 = pkt_q[first + 4];
            ok = (w1[31:16] == 16'h0800) && (w1[15:8] == 8'h45);
            s = w1[15:0];
            for (int k = 0; k < 4; k++) s += w2[16*k +: 16];
            for (int k = 0; k < 3; k++) s += w3[16*k +: 16];
            s += w4[63:48];
            while (s > 32'hFFFF) s = (s & 32'hFFFF) + (s >> 16);
            w3[63:48] = ~s[15:0];
        end
        foreach (pkt_q[i]) begin
            if (ok && i == first + 3) exp_q.push_back(w3);
            else exp_q.push_back(pkt_q[i]);
        end
        if (ok) e_ins++;
        else e_byp++;
    endfunction

    task automatic send_pkt(input int nwords);
        int t;
        for (int i = 0; i < nwords && !stuck; i++) begin
            in_wr = 1'b1;
            {in_ctrl, in_data} = pkt_q[i];
            t = 0;
            do begin
                @(negedge clk);
                t++;
            end while (!in_rdy && t < 400);
            if (!in_rdy) begin
                n_vec++;
                n_miss++;
                $display("FAIL in_rdy_timeout: word %0d waited %0d cycles, required acceptance", i, t);
                stuck = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        in_wr = 1'b0;
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (got_q.size() < exp_q.size() && t < 3000) begin
            @(negedge clk);
            t++;
        end
        repeat (20) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        in_wr   = 1'b1;
        in_ctrl = 8'hFF;
        in_data = {$urandom, $urandom};
        repeat (3) @(negedge clk);
        n_vec++;
        if ({out_wr, out_ctrl, out_data} !== 73'd0) begin
            n_miss++;
            $display("FAIL reset_out: got %h, required 0", {out_wr, out_ctrl, out_data});
        end
        n_vec++;
        if ({csum_inserted, csum_bypassed, in_rdy} !== 3'b000) begin
            n_miss++;
            $display("FAIL reset_flags: got ins/byp/rdy=%b, required 000", {csum_inserted, csum_bypassed, in_rdy});
        end
        in_wr   = 1'b0;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_known_ipv4(input logic [15:0] old_csum, input string name);
        logic [71:0] w;
        start_test();
        make_pkt(1, 8, 16'h0800, 8'h45);
        w = pkt_q[2]; w[15:0] = 16'h4500; pkt_q[2] = w;
        pkt_q[3] = {8'h00, 64'h0073_0000_4000_4011};
        w = pkt_q[4]; w[63:0] = {old_csum, 48'hc0a8_0001_c0a8}; pkt_q[4] = w;
        w = pkt_q[5]; w[63:48] = 16'h00c7; pkt_q[5] = w;
        build_expected();
        send_pkt(pkt_q.size());
        wait_drain();
        n_vec++;
        if (got_q.size() != exp_q.size()) begin
            n_miss++;
            $display("FAIL %s_len: got %0d words, required %0d", name, got_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            n_vec++;
            if (got_q[i] !== exp_q[i]) begin
                n_miss++;
                $display("FAIL %s_word%0d: got %h, required %h", name, i, got_q[i], exp_q[i]);
            end
        end
        w = (got_q.size() > 4) ? got_q[4] : 72'd0;
        n_vec++;
        if (w[63:48] !== 16'hB861) begin
            n_miss++;
            $display("FAIL %s_csum: got %h, required b861", name, w[63:48]);
        end
        n_vec++;
        if (ins_cnt != 1 || byp_cnt != 0) begin
            n_miss++;
            $display("FAIL %s_pulses: got ins=%0d byp=%0d, required ins=1 byp=0", name, ins_cnt, byp_cnt);
        end
    endtask

    task automatic test_bypass(input logic [15:0] etype, input logic [7:0] vi, input string name);
        start_test();
        make_pkt(1, 7, etype, vi);
        build_expected();
        send_pkt(pkt_q.size());
        wait_drain();
        n_vec++;
        if (got_q.size() != pkt_q.size()) begin
            n_miss++;
            $display("FAIL %s_len: got %0d words, required %0d", name, got_q.size(), pkt_q.size());
        end
        foreach (pkt_q[i]) if (i < got_q.size()) begin
            n_vec++;
            if (got_q[i] !== pkt_q[i]) begin
                n_miss++;
                $display("FAIL %s_word%0d: got %h, required %h", name, i, got_q[i], pkt_q[i]);
            end
        end
        n_vec++;
        if (ins_cnt != 0 || byp_cnt != 1) begin
            n_miss++;
            $display("FAIL %s_pulses: got ins=%0d byp=%0d, required ins=0 byp=1", name, ins_cnt, byp_cnt);
        end
    endtask

    task automatic test_short_then_normal();
        start_test();
        make_pkt(0, 3, 16'h0800, 8'h45);
        build_expected();
        send_pkt(pkt_q.size());
        make_pkt(1, 6, 16'h0800, 8'h45);
        build_expected();
        send_pkt(pkt_q.size());
        wait_drain();
        n_vec++;
        if (got_q.size() != exp_q.size()) begin
            n_miss++;
            $display("FAIL short_len: got %0d words, required %0d", got_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            n_vec++;
            if (got_q[i] !== exp_q[i]) begin
                n_miss++;
                $display("FAIL short_word%0d: got %h, required %h", i, got_q[i], exp_q[i]);
            end
        end
        n_vec++;
        if (ins_cnt != e_ins || byp_cnt != e_byp) begin
            n_miss++;
            $display("FAIL short_pulses: got ins=%0d byp=%0d, required ins=%0d byp=%0d", ins_cnt, byp_cnt, e_ins, e_byp);
        end
    endtask

    task automatic test_back_to_back(input int n_pkts, input bit mixed, input string name);
        logic [15:0] et;
        logic [7:0]  vi;
        start_test();
        rand_rdy = 1'b1;
        for (int p = 0; p < n_pkts; p++) begin
            et = (mixed && $urandom_range(0, 3) == 0) ? 16'h0806 : 16'h0800;
            vi = (mixed && $urandom_range(0, 3) == 0) ? 8'h46 : 8'h45;
            make_pkt($urandom_range(0, 2), mixed ? $urandom_range(2, 9) : $urandom_range(5, 9), et, vi);
            build_expected();
            send_pkt(pkt_q.size());
        end
        wait_drain();
        rand_rdy = 1'b0;
        n_vec++;
        if (got_q.size() != exp_q.size()) begin
            n_miss++;
            $display("FAIL %s_len: got %0d words, required %0d", name, got_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            n_vec++;
            if (got_q[i] !== exp_q[i]) begin
                n_miss++;
                $display("FAIL %s_word%0d: got %h, required %h", name, i, got_q[i], exp_q[i]);
            end
        end
        n_vec++;
        if (ins_cnt != e_ins || byp_cnt != e_byp) begin
            n_miss++;
            $display("FAIL %s_pulses: got ins=%0d byp=%0d, required ins=%0d byp=%0d", name, ins_cnt, byp_cnt, e_ins, e_byp);
        end
    endtask

    task automatic test_reset_in_drain();
        int t;
        start_test();
        hold_rdy = 1'b1;
        @(posedge clk);
        #2;
        make_pkt(0, 7, 16'h0800, 8'h45);
        send_pkt(5);
        t = 0;
        while (!csum_inserted && t < 30) begin
            @(negedge clk);
            t++;
        end
        n_vec++;
        if (!csum_inserted) begin
            n_miss++;
            $display("FAIL drain_start: got no insert pulse in %0d cycles, required one", t);
        end
        @(posedge clk);
        #2;
        n_vec++;
        if (out_wr !== 1'b1 || {out_ctrl, out_data} !== pkt_q[0]) begin
            n_miss++;
            $display("FAIL drain_w0: got wr=%b word=%h, required wr=1 word=%h", out_wr, {out_ctrl, out_data}, pkt_q[0]);
        end
        reset_n = 1'b0;
        #1;
        n_vec++;
        if ({out_wr, in_rdy, out_data} !== 66'd0) begin
            n_miss++;
            $display("FAIL drain_reset: got wr=%b rdy=%b data=%h, required all 0", out_wr, in_rdy, out_data);
        end
        @(negedge clk);
        @(negedge clk);
        reset_n  = 1'b1;
        hold_rdy = 1'b0;
        @(posedge clk);
        #1;
        start_test();
        make_pkt(1, 6, 16'h0800, 8'h45);
        build_expected();
        send_pkt(pkt_q.size());
        wait_drain();
        n_vec++;
        if (got_q.size() != exp_q.size()) begin
            n_miss++;
            $display("FAIL post_reset_len: got %0d words, required %0d", got_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            n_vec++;
            if (got_q[i] !== exp_q[i]) begin
                n_miss++;
                $display("FAIL post_reset_word%0d: got %h, required %h", i, got_q[i], exp_q[i]);
            end
        end
        n_vec++;
        if (ins_cnt != 1 || byp_cnt != 0) begin
            n_miss++;
            $display("FAIL post_reset_pulses: got ins=%0d byp=%0d, required ins=1 byp=0", ins_cnt, byp_cnt);
        end
    endtask

    initial begin
        reset_n  = 1'b0;
        in_wr    = 1'b0;
        in_data  = 64'd0;
        in_ctrl  = 8'd0;
        rand_rdy = 1'b0;
        hold_rdy = 1'b0;
        stuck    = 1'b0;
        test_reset();
        test_known_ipv4(16'h0000, "ipv4_zero_csum");
        test_known_ipv4(16'h1234, "ipv4_old_csum");
        test_bypass(16'h0806, 8'h45, "arp");
        test_bypass(16'h0800, 8'h46, "ihl6");
        test_short_then_normal();
        test_back_to_back(2, 1'b0, "b2b_ipv4");
        test_back_to_back(8, 1'b1, "b2b_mixed");
        test_reset_in_drain();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
